apb_requester: RTL and testbench



---
 rtl/apb_requester_if.sv | 48 ++++
 rtl/apb_requester.sv | 127 ++++++++++++
 tb/tb_apb_requester.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_requester_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_requester_if
// Description : Command/response handshake and APB bus bundle for apb_requester.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_requester_if #(
    parameter int ADDWIDTH  = 8,
    parameter int DATAWIDTH = 32
);
    // Local controller command side
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [ADDWIDTH-1:0]    cmd_addr;
    logic [DATAWIDTH-1:0]   cmd_wdata;
    logic [DATAWIDTH/8-1:0] cmd_strb;

    // Response pulse
    logic                   rsp_valid;
    logic [DATAWIDTH-1:0]   rsp_rdata;
    logic                   rsp_error;

    // APB bus
    logic                   PSEL;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [ADDWIDTH-1:0]    PADDR;
    logic [DATAWIDTH-1:0]   PWDATA;
    logic [DATAWIDTH/8-1:0] PSTRB;
    logic [DATAWIDTH-1:0]   PRDATA;
    logic                   PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );
endinterface
`default_nettype wire

// File: rtl/apb_requester.sv
`default_nettype none
// ============================================================================
// Module      : apb_requester
// Description : APB initiator; one APB transfer per valid/ready command,
//               one-cycle response pulse, PREADY wait-state timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_requester #(
    parameter int ADDWIDTH       = 8,
    parameter int DATAWIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          PCLK,
    input  logic          PRESET,
    apb_requester_if.master bus
);

    localparam int c_STRBW  = DATAWIDTH / 8;
    localparam int c_CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit c_TO_EN  = (TIMEOUT_CYCLES > 0);

    // Abort fires on the edge where the count would reach the limit.
    localparam logic [c_CNT_W-1:0] c_TO_LAST =
        c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;

    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_wait_cnt;
    logic                   r_cmd_ready;
    logic                   r_rsp_valid;
    logic [DATAWIDTH-1:0]   r_rsp_rdata;
    logic                   r_rsp_error;
    logic                   r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [ADDWIDTH-1:0]    r_paddr;
    logic [DATAWIDTH-1:0]   r_pwdata;
    logic [c_STRBW-1:0]     r_pstrb;

    logic                   w_accept;
    logic                   w_timeout;

    assign w_accept  = bus.cmd_valid && r_cmd_ready && (r_state == c_IDLE);
    assign w_timeout = c_TO_EN && (r_wait_cnt == c_TO_LAST);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= c_IDLE;
            r_wait_cnt  <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_pwrite    <= bus.cmd_write;
                        r_paddr     <= bus.cmd_addr;
                        r_pwdata    <= bus.cmd_wdata;
                        r_pstrb     <= bus.cmd_write ? bus.cmd_strb : '0;
                        r_psel      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_wait_cnt  <= '0;
                        r_state     <= c_SETUP;
                    end
                end
                c_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= c_ACCESS;
                end
                c_ACCESS: begin
                    // PREADY takes priority over a simultaneous timeout.
                    if (bus.PREADY) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b0;
                        r_rsp_rdata <= r_pwrite ? '0 : bus.PRDATA;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= c_IDLE;
                    end else if (w_timeout) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= c_IDLE;
                    end else if (r_wait_cnt != c_CNT_MAX) begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_error = r_rsp_error;
    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.PSTRB     = r_pstrb;

endmodule
`default_nettype wire

// File: tb/tb_apb_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_requester
// Description : Directed self-checking bench for apb_requester with a
//               memory-backed APB completer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_requester;

    logic PCLK;
    logic PRESET;
    int   n_pass  = 0;
    int   n_total = 0;

    int   wait_states = 0;
    logic hang        = 1'b0;
    int   acc_cnt     = 0;
    logic [31:0] mem [0:255];

    apb_requester_if #(.ADDWIDTH(8), .DATAWIDTH(32)) bus ();

    apb_requester #(
        .ADDWIDTH      (8),
        .DATAWIDTH     (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Memory-backed completer with programmable wait states / hang.
    always_comb begin
        bus.PREADY = bus.PSEL && bus.PENABLE && !hang && (acc_cnt >= wait_states);
        bus.PRDATA = mem[bus.PADDR];
    end

    always @(posedge PCLK) begin
        if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
        else                                         acc_cnt <= 0;
        if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE)
            for (int b = 0; b < 4; b++)
                if (bus.PSTRB[b]) mem[bus.PADDR][8*b +: 8] <= bus.PWDATA[8*b +: 8];
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_strb  = strb;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max_cyc);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.rsp_valid && n < max_cyc);
        chk("rsp_seen", {31'd0, bus.rsp_valid}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        PRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;

        // Reset state
        step();
        step();
        chk("rst_psel",    {31'd0, bus.PSEL},      32'd0);
        chk("rst_penable", {31'd0, bus.PENABLE},   32'd0);
        chk("rst_rspv",    {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_paddr",   {24'd0, bus.PADDR},     32'd0);
        PRESET = 1'b0;
        step();
        chk("rst_ready",   {31'd0, bus.cmd_ready}, 32'd1);

        // Zero-wait write
        issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
        chk("wr_setup_psel",    {31'd0, bus.PSEL},      32'd1);
        chk("wr_setup_penable", {31'd0, bus.PENABLE},   32'd0);
        chk("wr_setup_ready",   {31'd0, bus.cmd_ready}, 32'd0);
        chk("wr_setup_paddr",   {24'd0, bus.PADDR},     32'h10);
        chk("wr_setup_pwdata",  bus.PWDATA,             32'hDEADBEEF);
        chk("wr_setup_pstrb",   {28'd0, bus.PSTRB},     32'hF);
        chk("wr_setup_pwrite",  {31'd0, bus.PWRITE},    32'd1);
        bus.cmd_addr  = 8'h99;
        bus.cmd_wdata = 32'h0;
        step();
        chk("wr_acc_psel",    {31'd0, bus.PSEL},    32'd1);
        chk("wr_acc_penable", {31'd0, bus.PENABLE}, 32'd1);
        chk("wr_acc_paddr",   {24'd0, bus.PADDR},   32'h10);
        chk("wr_acc_pwdata",  bus.PWDATA,           32'hDEADBEEF);
        chk("wr_acc_pstrb",   {28'd0, bus.PSTRB},   32'hF);
        step();
        chk("wr_rspv",  {31'd0, bus.rsp_valid}, 32'd1);
        chk("wr_err",   {31'd0, bus.rsp_error}, 32'd0);
        chk("wr_rdata", bus.rsp_rdata,          32'd0);
        chk("wr_psel",  {31'd0, bus.PSEL},      32'd0);
        chk("wr_ready", {31'd0, bus.cmd_ready}, 32'd1);
        step();
        chk("wr_rspv_1cyc", {31'd0, bus.rsp_valid}, 32'd0);

        // Readback
        issue(1'b0, 8'h10, 32'h12345678, 4'hF);
        chk("rd_setup_pwrite", {31'd0, bus.PWRITE}, 32'd0);
        chk("rd_setup_pstrb",  {28'd0, bus.PSTRB},  32'd0);
        step();
        chk("rd_acc_pwrite", {31'd0, bus.PWRITE}, 32'd0);
        chk("rd_acc_pstrb",  {28'd0, bus.PSTRB},  32'd0);
        step();
        chk("rd_rspv",  {31'd0, bus.rsp_valid}, 32'd1);
        chk("rd_rdata", bus.rsp_rdata,          32'hDEADBEEF);
        step();

        // Partial strobe write then readback
        issue(1'b1, 8'h10, 32'h11223344, 4'h5);
        wait_rsp(10);
        step();
        issue(1'b0, 8'h10, 32'h0, 4'h0);
        wait_rsp(10);
        chk("ps_rdata", bus.rsp_rdata, 32'hDE22BE44);
        step();

        // Three wait states: four ACCESS cycles, completes just inside the timeout
        wait_states = 3;
        issue(1'b0, 8'h10, 32'h0, 4'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("ws_psel",    {31'd0, bus.PSEL},      32'd1);
            chk("ws_penable", {31'd0, bus.PENABLE},   32'd1);
            chk("ws_paddr",   {24'd0, bus.PADDR},     32'h10);
            chk("ws_ready",   {31'd0, bus.cmd_ready}, 32'd0);
            chk("ws_rspv",    {31'd0, bus.rsp_valid}, 32'd0);
            step();
        end
        chk("ws_done_rspv",  {31'd0, bus.rsp_valid}, 32'd1);
        chk("ws_done_err",   {31'd0, bus.rsp_error}, 32'd0);
        chk("ws_done_rdata", bus.rsp_rdata,          32'hDE22BE44);
        step();
        chk("ws_rspv_1cyc", {31'd0, bus.rsp_valid}, 32'd0);
        wait_states = 0;

        // Timeout after four ACCESS cycles with PREADY stuck low
        hang = 1'b1;
        issue(1'b0, 8'h10, 32'h0, 4'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("to_penable", {31'd0, bus.PENABLE},   32'd1);
            chk("to_rspv",    {31'd0, bus.rsp_valid}, 32'd0);
            step();
        end
        chk("to_done_rspv",  {31'd0, bus.rsp_valid}, 32'd1);
        chk("to_done_err",   {31'd0, bus.rsp_error}, 32'd1);
        chk("to_done_rdata", bus.rsp_rdata,          32'd0);
        chk("to_done_psel",  {31'd0, bus.PSEL},      32'd0);
        chk("to_done_ready", {31'd0, bus.cmd_ready}, 32'd1);
        hang = 1'b0;
        step();

        // Back-to-back: command held valid, SETUPs three cycles apart
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 8'h30;
        bus.cmd_wdata = 32'hA5A5A5A5;
        bus.cmd_strb  = 4'hF;
        step();
        chk("b2b_setup1", {30'd0, bus.PSEL, bus.PENABLE}, 32'h2);
        chk("b2b_addr1",  {24'd0, bus.PADDR},             32'h30);
        bus.cmd_addr = 8'h34;
        step();
        chk("b2b_access1", {30'd0, bus.PSEL, bus.PENABLE}, 32'h3);
        step();
        chk("b2b_rsp_ready", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'h3);
        step();
        chk("b2b_setup2", {30'd0, bus.PSEL, bus.PENABLE}, 32'h2);
        chk("b2b_addr2",  {24'd0, bus.PADDR},             32'h34);
        bus.cmd_valid = 1'b0;
        wait_rsp(10);
        step();
        chk("b2b_mem34", mem[8'h34], 32'hA5A5A5A5);

        // Reset during ACCESS aborts silently
        issue(1'b0, 8'h30, 32'h0, 4'h0);
        step();
        chk("rs_in_access", {30'd0, bus.PSEL, bus.PENABLE}, 32'h3);
        PRESET = 1'b1;
        step();
        chk("rs_psel",    {31'd0, bus.PSEL},      32'd0);
        chk("rs_penable", {31'd0, bus.PENABLE},   32'd0);
        chk("rs_rspv",    {31'd0, bus.rsp_valid}, 32'd0);
        PRESET = 1'b0;
        step();
        chk("rs_ready",  {31'd0, bus.cmd_ready}, 32'd1);
        chk("rs_rspv2",  {31'd0, bus.rsp_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
